// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: commit-record capture bus and show-ahead pop port
interface commit_trace_buffer_if #(
    parameter int XLEN = 32
) ();
    logic            commit_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic [4:0]      rd_addr_i;
    logic [XLEN-1:0] rd_data_i;
    logic            stall_i;
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [XLEN-1:0] rd_pc_o;
    logic [XLEN-1:0] rd_instr_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_stall_o;

    modport master (
        output commit_valid_i, pc_i, instr_i, rd_addr_i, rd_data_i, stall_i, rd_ready_i,
        input  rd_valid_o, rd_pc_o, rd_instr_o, rd_addr_o, rd_data_o, rd_stall_o
    );

    modport slave (
        input  commit_valid_i, pc_i, instr_i, rd_addr_i, rd_data_i, stall_i, rd_ready_i,
        output rd_valid_o, rd_pc_o, rd_instr_o, rd_addr_o, rd_data_o, rd_stall_o
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular capture buffer of commit records with stop/wrap full modes
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic                   mode_wrap_i,
    input  logic                   skip_stall_i,
    commit_trace_buffer_if.slave   trc,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CNT_W-1:0]       drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            stall;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             wr_rec;
    rec_t             rd_rec;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             push, pop, drop, wr_en, rd_adv;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign drop_cnt_o = drop_q;

    assign rd_rec         = mem_q[rptr_q];
    assign trc.rd_valid_o = ~empty_o;
    assign trc.rd_pc_o    = rd_rec.pc;
    assign trc.rd_instr_o = rd_rec.instr;
    assign trc.rd_addr_o  = rd_rec.addr;
    assign trc.rd_data_o  = rd_rec.data;
    assign trc.rd_stall_o = rd_rec.stall;

    // Next-state: overwrite-when-full advances the read pointer alongside the write pointer
    always_comb begin
        push    = en_i & trc.commit_valid_i & ~(skip_stall_i & trc.stall_i);
        pop     = ~empty_o & trc.rd_ready_i;
        drop    = push & full_o & ~pop;
        wr_en   = push & (~full_o | pop | mode_wrap_i);
        rd_adv  = pop | (drop & mode_wrap_i);
        wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_adv ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_adv);
        drop_d  = (drop & ~&drop_q) ? drop_q + 1'b1 : drop_q;
        wr_rec  = '{pc: trc.pc_i, instr: trc.instr_i, addr: trc.rd_addr_i,
                    data: (trc.rd_addr_i == 5'd0) ? '0 : trc.rd_data_i, stall: trc.stall_i};
    end

    // Pointer, occupancy and drop-counter state; clear behaves exactly like reset
    always_ff @(posedge clk_i) begin
        if (!rstn || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Record storage, not reset; only ever read where count says it is valid
    always_ff @(posedge clk_i) begin
        if (rstn && !clear_i && wr_en) mem_q[wptr_q] <= wr_rec;
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed plan plus randomized traffic against a queue reference model
module tb_commit_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
    } rec_t;

    logic                   clk_i = 1'b0;
    logic                   rstn, clear_i, en_i, mode_wrap_i, skip_stall_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   full_o, empty_o;
    logic [CNT_W-1:0]       drop_cnt_o;
    int                     checks = 0;
    int                     errors = 0;
    rec_t                   mq[$];
    int                     mdrop = 0;
    logic [31:0]            got[$];
    logic [31:0]            expq[$];

    always #5 clk_i = ~clk_i;

    commit_trace_buffer_if #(.XLEN(XLEN)) trc ();

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rstn(rstn), .clear_i(clear_i), .en_i(en_i),
        .mode_wrap_i(mode_wrap_i), .skip_stall_i(skip_stall_i), .trc(trc),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .drop_cnt_o(drop_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        rec_t r;
        if (!rstn || clear_i) begin
            mq.delete();
            mdrop = 0;
            return;
        end
        r = '{pc: trc.pc_i, instr: trc.instr_i, addr: trc.rd_addr_i,
              data: (trc.rd_addr_i == 5'd0) ? 32'd0 : trc.rd_data_i, stall: trc.stall_i};
        if (mq.size() != 0 && trc.rd_ready_i) void'(mq.pop_front());
        if (en_i && trc.commit_valid_i && !(skip_stall_i && trc.stall_i)) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                if (mode_wrap_i) begin
                    void'(mq.pop_front());
                    mq.push_back(r);
                end
                if (mdrop < 2**CNT_W - 1) mdrop++;
            end
        end
    endtask

    task automatic compare();
        check("count", 64'(count_o), 64'(mq.size()));
        check("full", 64'(full_o), 64'(mq.size() == DEPTH));
        check("empty", 64'(empty_o), 64'(mq.size() == 0));
        check("rd_valid", 64'(trc.rd_valid_o), 64'(mq.size() != 0));
        check("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
        if (mq.size() != 0) begin
            check("rd_pc", 64'(trc.rd_pc_o), 64'(mq[0].pc));
            check("rd_instr", 64'(trc.rd_instr_o), 64'(mq[0].instr));
            check("rd_addr", 64'(trc.rd_addr_o), 64'(mq[0].addr));
            check("rd_data", 64'(trc.rd_data_o), 64'(mq[0].data));
            check("rd_stall", 64'(trc.rd_stall_o), 64'(mq[0].stall));
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        #1;
        compare();
    endtask

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [4:0] addr,
                       input logic [31:0] data, input logic st, input logic rdy);
        trc.commit_valid_i = v;
        trc.pc_i           = pc;
        trc.instr_i        = ~pc;
        trc.rd_addr_i      = addr;
        trc.rd_data_i      = data;
        trc.stall_i        = st;
        trc.rd_ready_i     = rdy;
        tick();
        trc.commit_valid_i = 1'b0;
        trc.rd_ready_i     = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
    endtask

    task automatic drain();
        got.delete();
        for (int i = 0; i < 2*DEPTH && trc.rd_valid_o; i++) begin
            got.push_back(trc.rd_pc_o);
            cyc(0, 0, 0, 0, 0, 1);
        end
        check("drain_empty", 64'(empty_o), 64'd1);
    endtask

    task automatic check_drain(input string tag);
        check({tag, "_len"}, 64'(got.size()), 64'(expq.size()));
        foreach (expq[i]) check(tag, (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(expq[i]));
    endtask

    task automatic fill20(input logic wrap);
        mode_wrap_i = wrap;
        for (int i = 0; i < 20; i++) cyc(1, 32'(4*i), 5'(i % 31 + 1), $urandom, 0, 0);
    endtask

    initial begin
        int rdy_pct;
        rstn = 1'b0; clear_i = 1'b0; en_i = 1'b1; mode_wrap_i = 1'b0; skip_stall_i = 1'b0;
        trc.commit_valid_i = 1'b0; trc.rd_ready_i = 1'b0;
        trc.pc_i = '0; trc.instr_i = '0; trc.rd_addr_i = '0; trc.rd_data_i = '0; trc.stall_i = 1'b0;
        do_reset();
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_valid", 64'(trc.rd_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);

        cyc(1, 32'h0, 5'd1, 32'h11, 0, 0);
        check("first_pc", 64'(trc.rd_pc_o), 64'd0);
        cyc(1, 32'h4, 5'd2, 32'h22, 0, 0);
        cyc(1, 32'h8, 5'd3, 32'h33, 0, 0);
        check("count3", 64'(count_o), 64'd3);
        drain();
        expq = '{32'h0, 32'h4, 32'h8};
        check_drain("drain3");

        do_reset();
        fill20(1'b0);
        check("stop_full", 64'(full_o), 64'd1);
        check("stop_drop", 64'(drop_cnt_o), 64'd4);
        drain();
        expq.delete();
        for (int i = 0; i < 16; i++) expq.push_back(32'(4*i));
        check_drain("stop_pcs");

        do_reset();
        fill20(1'b1);
        check("wrap_count", 64'(count_o), 64'd16);
        check("wrap_drop", 64'(drop_cnt_o), 64'd4);
        drain();
        expq.delete();
        for (int i = 4; i < 20; i++) expq.push_back(32'(4*i));
        check_drain("wrap_pcs");

        fill20(1'b1);
        for (int i = 0; i < 12; i++) cyc(1, 32'h1000 + 32'(i), 5'd7, $urandom, 0, 0);
        check("drop_sat", 64'(drop_cnt_o), 64'd15);

        do_reset();
        mode_wrap_i = 1'b0;
        for (int i = 0; i < 16; i++) cyc(1, 32'(4*i), 5'd1, $urandom, 0, 0);
        cyc(1, 32'h999, 5'd2, $urandom, 0, 1);
        check("pp_stop_count", 64'(count_o), 64'd16);
        check("pp_stop_drop", 64'(drop_cnt_o), 64'd0);
        mode_wrap_i = 1'b1;
        cyc(1, 32'haaa, 5'd3, $urandom, 0, 1);
        check("pp_wrap_count", 64'(count_o), 64'd16);
        check("pp_wrap_drop", 64'(drop_cnt_o), 64'd0);
        drain();
        expq.delete();
        for (int i = 2; i < 16; i++) expq.push_back(32'(4*i));
        expq.push_back(32'h999);
        expq.push_back(32'haaa);
        check_drain("pp_pcs");

        do_reset();
        mode_wrap_i = 1'b0;
        skip_stall_i = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1, 32'h200 + 32'(4*i), 5'd5, $urandom, 1'(i % 2), 0);
        check("skip_count", 64'(count_o), 64'd3);
        drain();
        expq = '{32'h200, 32'h208, 32'h210};
        check_drain("skip_pcs");
        skip_stall_i = 1'b0;
        cyc(1, 32'h300, 5'd0, 32'hdeadbeef, 0, 0);
        check("x0_data", 64'(trc.rd_data_o), 64'd0);
        check("x0_addr", 64'(trc.rd_addr_o), 64'd0);

        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 5; i++) cyc(1, 32'h40 + 32'(i), 5'd4, $urandom, 0, 0);
            if (k == 0) rstn = 1'b0; else clear_i = 1'b1;
            cyc(1, 32'h77, 5'd4, $urandom, 0, 1);
            rstn = 1'b1;
            clear_i = 1'b0;
            check("flush_count", 64'(count_o), 64'd0);
            check("flush_drop", 64'(drop_cnt_o), 64'd0);
            check("flush_valid", 64'(trc.rd_valid_o), 64'd0);
            cyc(1, 32'h100, 5'd9, $urandom, 0, 0);
            check("flush_next_pc", 64'(trc.rd_pc_o), 64'h100);
        end

        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = (i / 200 % 3 == 0) ? 10 : (i / 200 % 3 == 1) ? 90 : 50;
            rstn         = $urandom_range(199) != 0;
            clear_i      = $urandom_range(149) == 0;
            en_i         = $urandom_range(9) != 0;
            mode_wrap_i  = 1'($urandom_range(1));
            skip_stall_i = 1'($urandom_range(1));
            cyc(1'($urandom_range(3) != 0), $urandom,
                ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom,
                1'($urandom_range(1)), 1'($urandom_range(99) < rdy_pct));
        end
        rstn = 1'b1;
        clear_i = 1'b0;
        en_i = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
